// File: rtl/debounce_multi_pkg.sv
// Shared constants and types for the multi-channel push-button debouncer.
// Defaults and legal synchroniser depth live here so every file agrees on them.
package debounce_multi_pkg;

    localparam int N_CH_DEF        = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int HOLD_W_DEF      = 24;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } btn_state_e;

    function automatic bit sync_stages_ok(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button pins in, debounced level and event pulses out; bit i belongs to channel i.
// master = board/user side, slave = debouncer.
interface debounce_multi_if
    import debounce_multi_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
);
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] button_state;
    logic [N_CH-1:0] button_down;
    logic [N_CH-1:0] button_up;
    logic [N_CH-1:0] button_long;

    modport master (
        output button,
        input  button_state,
        input  button_down,
        input  button_up,
        input  button_long
    );

    modport slave (
        input  button,
        output button_state,
        output button_down,
        output button_up,
        output button_long
    );
endinterface

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser, stability counter, press/release FSM and hold timer.
// The pin arriving here is already polarity corrected (1 = pressed).
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_RELEASED  | debounced level 0; counting a stable 1 on sync to press
//   ST_PRESSED   | debounced level 1; counting a stable 0 to release, hold timer runs
module debounce_chan
    import debounce_multi_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_W      = HOLD_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic state,
    output logic down,
    output logic up,
    output logic long_press
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("debounce_chan: SYNC_STAGES=%0d outside legal range %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
    if (CNT_W < 1 || HOLD_W < 2) begin : g_bad_widths
        $error("debounce_chan: CNT_W=%0d must be >=1 and HOLD_W=%0d must be >=2", CNT_W, HOLD_W);
    end

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_PRE = {{(HOLD_W-1){1'b1}}, 1'b0};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    btn_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   down_q, down_d;
    logic                   up_q, up_d;
    logic                   long_q, long_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            hold_q  <= '0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            down_q  <= down_d;
            up_q    <= up_d;
            long_q  <= long_d;
        end
    end

    // Counter clears whenever sync agrees with the debounced level, so a glitch leaves no trace.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        hold_d  = '0;
        down_d  = 1'b0;
        up_d    = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (sync) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = ST_PRESSED;
                        down_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_PRESSED: begin
                if (!sync) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = ST_RELEASED;
                        up_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                // A release on this edge wins over saturation: hold clears, no long pulse.
                if (state_d == ST_PRESSED) begin
                    hold_d = hold_q;
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_ONE;
                        long_d = (hold_q == HOLD_PRE);
                    end
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    assign state      = (state_q == ST_PRESSED);
    assign down       = down_q;
    assign up         = up_q;
    assign long_press = long_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: corrects pin polarity and fans the bus out
// to one independent debounce_chan per button.
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ACTIVE_LOW  = 1,
    parameter int HOLD_W      = HOLD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    debounce_multi_if.slave  bus
);

    logic [N_CH-1:0] pin_pol;
    logic [N_CH-1:0] state_v;
    logic [N_CH-1:0] down_v;
    logic [N_CH-1:0] up_v;
    logic [N_CH-1:0] long_v;

    assign pin_pol = (ACTIVE_LOW != 0) ? ~bus.button : bus.button;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_W      (HOLD_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .pin        (pin_pol[i]),
            .state      (state_v[i]),
            .down       (down_v[i]),
            .up         (up_v[i]),
            .long_press (long_v[i])
        );
    end

    assign bus.button_state = state_v;
    assign bus.button_down  = down_v;
    assign bus.button_up    = up_v;
    assign bus.button_long  = long_v;

endmodule

// File: tb/tb_debounce_multi.sv
// Event scoreboard bench for debounce_multi: expected pulses are queued with their
// cycle when a pin is driven and matched against every pulse the DUT raises.
module tb_debounce_multi;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 4;
    localparam int HOLD_W   = 6;
    localparam int SYNC     = 2;
    localparam int DEB_LAT  = SYNC + (1 << CNT_W);
    localparam int HOLD_LAT = (1 << HOLD_W) - 1;

    localparam int EV_DOWN = 0;
    localparam int EV_UP   = 1;
    localparam int EV_LONG = 2;

    typedef struct {
        int ch;
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  exp_q[$];

    debounce_multi_if #(.N_CH(N_CH)) bus ();

    debounce_multi #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .ACTIVE_LOW  (1),
        .HOLD_W      (HOLD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input int kind, input int at);
        ev_t e;
        e.ch   = ch;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press/release helpers: drive the pin just after an edge and queue the expected pulses.
    task automatic press(input int ch, input bit with_long);
        bus.button[ch] = 1'b0;
        push(ch, EV_DOWN, cyc + DEB_LAT);
        if (with_long) push(ch, EV_LONG, cyc + DEB_LAT + HOLD_LAT);
    endtask

    task automatic release_btn(input int ch);
        bus.button[ch] = 1'b1;
        push(ch, EV_UP, cyc + DEB_LAT);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check($sformatf("missed_event_ch%0d_kind%0d", exp_q[0].ch, exp_q[0].kind), cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if ((bus.button_down & bus.button_up) != '0)
            check("down_up_overlap", 32'(bus.button_down & bus.button_up), 0);
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                logic bitv;
                ev_t  e;
                bitv = (k == EV_DOWN) ? bus.button_down[ch] :
                       (k == EV_UP)   ? bus.button_up[ch]   : bus.button_long[ch];
                if (bitv === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("spurious_ch%0d_kind%0d", ch, k), 32'(bitv), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_chan", ch, e.ch);
                        check("ev_kind", k, e.kind);
                        check("ev_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.button = '1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(bus.button_state), 0);
        check("rst_down",  32'(bus.button_down), 0);
        check("rst_up",    32'(bus.button_up), 0);
        check("rst_long",  32'(bus.button_long), 0);
        tick(1);
        rst = 1'b0;

        // Idle with all pins released: any pulse is flagged as spurious.
        tick(100);
        check("idle_state", 32'(bus.button_state), 0);

        // Clean press then release on ch0.
        press(0, 1'b0);
        tick(30);
        check("t2_state", 32'(bus.button_state), 32'h1);
        release_btn(0);
        tick(30);
        check("t2_released", 32'(bus.button_state), 0);

        // Short glitch on ch1; a following press must still need the full count.
        bus.button[1] = 1'b0;
        tick(10);
        bus.button[1] = 1'b1;
        tick(40);
        check("t3_state", 32'(bus.button_state), 0);
        press(1, 1'b0);
        tick(30);
        check("t3_press", 32'(bus.button_state), 32'h2);
        release_btn(1);
        tick(30);

        // Long press on ch2, release, a press released exactly as hold saturates, then a new long press.
        press(2, 1'b1);
        tick(100);
        check("t4_held", 32'(bus.button_state), 32'h4);
        release_btn(2);
        tick(30);
        press(2, 1'b0);
        tick(HOLD_LAT);
        release_btn(2);
        tick(30);
        check("t4_sat_release", 32'(bus.button_state), 0);
        press(2, 1'b1);
        tick(100);
        release_btn(2);
        tick(30);

        // Bouncing ch3: toggles every 3 cycles, ends released, then a final stable press.
        for (int k = 0; k < 14; k++) begin
            bus.button[3] = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        press(3, 1'b0);
        tick(30);
        check("t5_state", 32'(bus.button_state), 32'h8);
        release_btn(3);
        tick(30);

        // Reset while ch0 counter holds 10: count restarts from the synchroniser refill.
        bus.button[0] = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_state", 32'(bus.button_state), 0);
        push(0, EV_DOWN, cyc + DEB_LAT);
        tick(30);
        check("t6_state", 32'(bus.button_state), 32'h1);
        release_btn(0);
        tick(30);

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
